// File: rtl/filter_gpu_pkg.sv
// Shared types and helpers for the filter GPU kernel-select controller.
// Optional feature macro used by this slice: KSEL_CYCLE_EN.
package filter_gpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FIRE
   } ksel_state_t;

   localparam int DEB_CYCLES_DEF = 4;
   localparam int PIX_DIV_DEF    = 2;

   // clog2 that never returns less than one bit
   function automatic int kw_f(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/kernel_select_ctrl_if.sv
// Button/busy inputs and kernel/restart/pixel outputs of the selector.
// Macro KSEL_CYCLE_EN adds the btn_next_n cycle button.
interface kernel_select_ctrl_if
   import filter_gpu_pkg::*;
#(
   parameter int N_KERNELS = 3
);

   localparam int KW = kw_f(N_KERNELS);

   logic [N_KERNELS-1:0] btn_n;
   logic                 busy;
   logic [KW-1:0]        kernel;
   logic                 restart;
   logic                 pend;
   logic                 pix_en;
`ifdef KSEL_CYCLE_EN
   logic                 btn_next_n;
`endif

   modport master (
`ifdef KSEL_CYCLE_EN
      output btn_next_n,
`endif
      output btn_n,
      output busy,
      input  kernel,
      input  restart,
      input  pend,
      input  pix_en
   );

   modport slave (
`ifdef KSEL_CYCLE_EN
      input  btn_next_n,
`endif
      input  btn_n,
      input  busy,
      output kernel,
      output restart,
      output pend,
      output pix_en
   );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability debouncer, press pulse.
// press fires for one cycle on a debounced 1->0 transition.
module btn_debounce
   import filter_gpu_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   localparam int CW = kw_f(DEB_CYCLES);

   logic          s1;
   logic          s2;
   logic          deb;
   logic [CW-1:0] cnt;

   // sync, count differing samples, flip level after DEB_CYCLES of them
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         deb   <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= btn_n;
         s2    <= s1;
         press <= 1'b0;
         if (s2 != deb) begin
            if (cnt == CW'(DEB_CYCLES - 1)) begin
               deb   <= s2;
               cnt   <= '0;
               press <= deb;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/kernel_select_ctrl.sv
// Kernel selection, busy-gated restart pulse and VGA pixel enable.
// Macro KSEL_CYCLE_EN adds a next-kernel cycle button.
module kernel_select_ctrl
   import filter_gpu_pkg::*;
#(
   parameter int N_KERNELS  = 3,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int PIX_DIV    = PIX_DIV_DEF
) (
   input  logic               clk,
   input  logic               reset,
   kernel_select_ctrl_if.slave bus
);

   localparam int KW = kw_f(N_KERNELS);
   localparam int PW = kw_f(PIX_DIV);
`ifdef KSEL_CYCLE_EN
   localparam int NB = N_KERNELS + 1;
`else
   localparam int NB = N_KERNELS;
`endif

   ksel_state_t   state;
   ksel_state_t   nxt;
   logic [NB-1:0] raw;
   logic [NB-1:0] ev;
   logic          hit;
   logic [KW-1:0] sel;
   logic [KW-1:0] nk_q;
   logic [KW-1:0] kern_q;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_nxt;
   logic          pix_q;
   logic          restart;
   logic          pend;
`ifdef KSEL_CYCLE_EN
   logic [KW-1:0] base;
`endif

   assign raw[N_KERNELS-1:0] = bus.btn_n;
`ifdef KSEL_CYCLE_EN
   assign raw[N_KERNELS] = bus.btn_next_n;
`endif

   for (genvar gi = 0; gi < NB; gi++) begin : g_deb
      btn_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk  (clk),
         .reset(reset),
         .btn_n(raw[gi]),
         .press(ev[gi])
      );
   end

`ifdef KSEL_CYCLE_EN
   assign base = (state == WAIT) ? nk_q : kern_q;
`endif

   // pick the winning press: lowest button index, cycle button last
   always_comb begin
      hit = 1'b0;
      sel = nk_q;
      for (int i = N_KERNELS - 1; i >= 0; i--) begin
         if (ev[i]) begin
            hit = 1'b1;
            sel = KW'(i);
         end
      end
`ifdef KSEL_CYCLE_EN
      if (!hit && ev[N_KERNELS]) begin
         hit = 1'b1;
         sel = (base == KW'(N_KERNELS - 1)) ? '0 : base + 1'b1;
      end
`endif
   end

   // state, latched selection and visible kernel
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         nk_q   <= '0;
         kern_q <= '0;
      end else begin
         state <= nxt;
         if (hit) nk_q <= sel;
         if (nxt == FIRE) kern_q <= sel;
      end
   end

   // next state: FIRE accepts new presses exactly like IDLE
   always_comb begin
      nxt = IDLE;
      unique case (state)
         IDLE, FIRE: begin
            if (hit) nxt = bus.busy ? WAIT : FIRE;
            else nxt = IDLE;
         end
         WAIT: nxt = bus.busy ? WAIT : FIRE;
         default: nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      restart = (state == FIRE);
      pend    = (state == WAIT);
   end

   assign pcnt_nxt = (pcnt == PW'(PIX_DIV - 1)) ? '0 : pcnt + 1'b1;

   // wrapping pixel divider; pix_en registered so it is 0 in reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt  <= '0;
         pix_q <= 1'b0;
      end else begin
         pcnt  <= pcnt_nxt;
         pix_q <= (pcnt_nxt == PW'(PIX_DIV - 1));
      end
   end

   assign bus.kernel  = kern_q;
   assign bus.restart = restart;
   assign bus.pend    = pend;
   assign bus.pix_en  = pix_q;

endmodule

// File: tb/tb_kernel_select_ctrl.sv
// Directed bench for kernel_select_ctrl (N_KERNELS=3, DEB=4, PIX_DIV=2).
// Define KSEL_CYCLE_EN to also exercise the cycle button.
module tb_kernel_select_ctrl;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   kernel_select_ctrl_if #(.N_KERNELS(3)) bus ();

   kernel_select_ctrl #(
      .N_KERNELS (3),
      .DEB_CYCLES(4),
      .PIX_DIV   (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b0;
      bus.btn_n = 3'b111;
      bus.busy = 1'b0;
`ifdef KSEL_CYCLE_EN
      bus.btn_next_n = 1'b1;
`endif
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.kernel !== 2'd0) begin
         n_err++;
         $display("FAIL reset_kernel got %0d want 0", bus.kernel);
      end
      n_cmp++;
      if ({bus.restart, bus.pend, bus.pix_en} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_outs got %b want 000",
                  {bus.restart, bus.pend, bus.pix_en});
      end
      reset = 1'b1;
   endtask

   task automatic test_latency();
      int first;
      int cnt;
      bit pseen;
      first = 0;
      cnt = 0;
      pseen = 0;
      @(negedge clk);
      bus.btn_n = 3'b101;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.restart) begin
            cnt++;
            if (first == 0) first = i;
         end
         if (bus.pend) pseen = 1;
         if (i == 10) bus.btn_n = 3'b111;
      end
      n_cmp++;
      if (first !== 7) begin
         n_err++;
         $display("FAIL lat_first got %0d want 7", first);
      end
      n_cmp++;
      if (cnt !== 1) begin
         n_err++;
         $display("FAIL lat_count got %0d want 1", cnt);
      end
      n_cmp++;
      if (bus.kernel !== 2'd1) begin
         n_err++;
         $display("FAIL lat_kernel got %0d want 1", bus.kernel);
      end
      n_cmp++;
      if (pseen !== 1'b0) begin
         n_err++;
         $display("FAIL lat_pend got %b want 0", pseen);
      end
   endtask

   task automatic press_hold(input logic [2:0] pat, output int rcnt);
      rcnt = 0;
      bus.btn_n = pat;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (bus.restart) rcnt++;
         if (i == 9) bus.btn_n = 3'b111;
      end
   endtask

   task automatic test_busy_wait();
      int r1;
      int r2;
      int r3;
      bit kok;
      r3 = 0;
      kok = 1;
      bus.busy = 1'b1;
      press_hold(3'b011, r1);
      n_cmp++;
      if ({bus.pend, bus.kernel} !== 3'b101) begin
         n_err++;
         $display("FAIL wait1 pend/kernel got %b/%0d want 1/1",
                  bus.pend, bus.kernel);
      end
      press_hold(3'b110, r2);
      n_cmp++;
      if ({bus.pend, bus.kernel} !== 3'b101) begin
         n_err++;
         $display("FAIL wait2 pend/kernel got %b/%0d want 1/1",
                  bus.pend, bus.kernel);
      end
      n_cmp++;
      if (r1 + r2 !== 0) begin
         n_err++;
         $display("FAIL wait_norst got %0d want 0", r1 + r2);
      end
      bus.busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.restart) begin
            r3++;
            if (bus.kernel !== 2'd0) kok = 0;
         end
      end
      n_cmp++;
      if (r3 !== 1) begin
         n_err++;
         $display("FAIL wait_rst got %0d want 1", r3);
      end
      n_cmp++;
      if ({kok, bus.kernel, bus.pend} !== 4'b1000) begin
         n_err++;
         $display("FAIL wait_final ok/kernel/pend got %b/%0d/%b want 1/0/0",
                  kok, bus.kernel, bus.pend);
      end
   endtask

   task automatic test_glitch();
      int r;
      r = 0;
      bus.btn_n = 3'b011;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.restart) r++;
         if (i == 2) bus.btn_n = 3'b111;
      end
      n_cmp++;
      if (r !== 0) begin
         n_err++;
         $display("FAIL glitch_rst got %0d want 0", r);
      end
      n_cmp++;
      if (bus.kernel !== 2'd0) begin
         n_err++;
         $display("FAIL glitch_kernel got %0d want 0", bus.kernel);
      end
   endtask

   task automatic test_simultaneous();
      int r;
      r = 0;
      bus.btn_n = 3'b001;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         if (bus.restart) r++;
      end
      bus.btn_n = 3'b111;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (r !== 1) begin
         n_err++;
         $display("FAIL simul_rst got %0d want 1", r);
      end
      n_cmp++;
      if (bus.kernel !== 2'd1) begin
         n_err++;
         $display("FAIL simul_kernel got %0d want 1", bus.kernel);
      end
   endtask

   task automatic test_pix_en();
      logic [3:0] got;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.pix_en !== 1'b0) begin
         n_err++;
         $display("FAIL pix_rel got %b want 0", bus.pix_en);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         got[i] = bus.pix_en;
      end
      n_cmp++;
      if (got !== 4'b0101) begin
         n_err++;
         $display("FAIL pix_seq got %b want 0101", got);
      end
   endtask

   task automatic test_reset_mid_wait();
      int r;
      bus.busy = 1'b1;
      press_hold(3'b011, r);
      n_cmp++;
      if (bus.pend !== 1'b1) begin
         n_err++;
         $display("FAIL mw_pend got %b want 1", bus.pend);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.pend, bus.kernel} !== 3'b000) begin
         n_err++;
         $display("FAIL mw_async pend/kernel got %b/%0d want 0/0",
                  bus.pend, bus.kernel);
      end
      @(negedge clk);
      reset = 1'b1;
      bus.busy = 1'b0;
      r = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.restart) r++;
      end
      n_cmp++;
      if (r !== 0) begin
         n_err++;
         $display("FAIL mw_norst got %0d want 0", r);
      end
   endtask

`ifdef KSEL_CYCLE_EN
   task automatic test_cycle();
      int r;
      press_hold(3'b011, r);
      n_cmp++;
      if (bus.kernel !== 2'd2) begin
         n_err++;
         $display("FAIL cyc_pre got %0d want 2", bus.kernel);
      end
      r = 0;
      bus.btn_next_n = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (bus.restart) r++;
         if (i == 9) bus.btn_next_n = 1'b1;
      end
      n_cmp++;
      if ({bus.kernel, 4'(r)} !== {2'd0, 4'd1}) begin
         n_err++;
         $display("FAIL cyc_wrap kernel/rst got %0d/%0d want 0/1",
                  bus.kernel, r);
      end
      r = 0;
      bus.btn_next_n = 1'b0;
      bus.btn_n = 3'b101;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (bus.restart) r++;
         if (i == 9) begin
            bus.btn_next_n = 1'b1;
            bus.btn_n = 3'b111;
         end
      end
      n_cmp++;
      if ({bus.kernel, 4'(r)} !== {2'd1, 4'd1}) begin
         n_err++;
         $display("FAIL cyc_prio kernel/rst got %0d/%0d want 1/1",
                  bus.kernel, r);
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_latency();
      test_busy_wait();
      test_glitch();
      test_simultaneous();
      test_pix_en();
      test_reset_mid_wait();
`ifdef KSEL_CYCLE_EN
      test_cycle();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
